// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants, FSM state and bit-slice operation encodings
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SL_AND = 2'd0,
        SL_OR  = 2'd1,
        SL_SUM = 2'd2
    } slice_op_t;

    // Opcodes handled by the slice chain in a single cycle
    function automatic logic is_chain_op(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT) || (op == OP_NOR);
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// rtl/alu_bit_slice.sv - one-bit ALU slice with operand inversion and carry chain
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic      a,
    input  logic      b,
    input  logic      ainvert,
    input  logic      binvert,
    input  logic      cin,
    input  slice_op_t operation,
    output logic      out,
    output logic      cout
);

    logic ai;
    logic bi;

    assign ai   = a ^ ainvert;
    assign bi   = b ^ binvert;
    assign cout = (ai & bi) | (cin & (ai ^ bi));

    always_comb begin
        out = 1'b0;
        case (operation)
            SL_AND:  out = ai & bi;
            SL_OR:   out = ai | bi;
            SL_SUM:  out = ai ^ bi ^ cin;
            default: out = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - single-cycle logic/arith ALU with multi-cycle shift-add multiplier
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_t            state;
    logic [CW-1:0]     iter_cnt;
    logic [WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]  prod_hi;
    logic [WIDTH-1:0]  prod_lo;

    logic              ainvert;
    logic              binvert;
    logic              cin;
    slice_op_t         slice_op;
    logic [WIDTH:0]    carry;
    logic [WIDTH-1:0]  slice_out;
    logic              add_ovf;

    logic [WIDTH-1:0]  alu_res;
    logic              alu_cout;
    logic              alu_ovf;
    logic              alu_valid;

    logic [WIDTH:0]    step_sum;
    logic [WIDTH-1:0]  next_hi;
    logic [WIDTH-1:0]  next_lo;

    always_comb begin
        ainvert  = (op == OP_NOR);
        binvert  = (op == OP_SUB) || (op == OP_SLT) || (op == OP_NOR);
        cin      = (op == OP_SUB) || (op == OP_SLT);
        slice_op = SL_AND;
        case (op)
            OP_OR:                   slice_op = SL_OR;
            OP_ADD, OP_SUB, OP_SLT:  slice_op = SL_SUM;
            default:                 slice_op = SL_AND;
        endcase
    end

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        alu_bit_slice u_slice (
            .a         (a[i]),
            .b         (b[i]),
            .ainvert   (ainvert),
            .binvert   (binvert),
            .cin       (carry[i]),
            .operation (slice_op),
            .out       (slice_out[i]),
            .cout      (carry[i+1])
        );
    end

    assign add_ovf = carry[WIDTH] ^ carry[WIDTH-1];

    always_comb begin
        alu_res   = '0;
        alu_cout  = 1'b0;
        alu_ovf   = 1'b0;
        alu_valid = is_chain_op(op);
        case (op)
            OP_AND, OP_OR, OP_NOR: alu_res = slice_out;
            OP_ADD, OP_SUB: begin
                alu_res  = slice_out;
                alu_cout = carry[WIDTH];
                alu_ovf  = add_ovf;
            end
            // Sign of a-b corrected by overflow gives the true signed compare
            OP_SLT: begin
                alu_res  = {{(WIDTH-1){1'b0}}, slice_out[WIDTH-1] ^ add_ovf};
                alu_cout = carry[WIDTH];
            end
            default: alu_res = '0;
        endcase
    end

    // One shift-add step: conditionally add multiplicand, then shift {hi,lo} right
    always_comb begin
        step_sum = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, mcand} : '0);
        next_hi  = step_sum[WIDTH:1];
        next_lo  = {step_sum[0], prod_lo[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            iter_cnt  <= '0;
            mcand     <= '0;
            prod_hi   <= '0;
            prod_lo   <= '0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (op == OP_MUL) begin
                            state    <= ST_MUL;
                            mcand    <= a;
                            prod_hi  <= '0;
                            prod_lo  <= b;
                            iter_cnt <= '0;
                        end else begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            result    <= alu_res;
                            result_hi <= '0;
                            zero      <= alu_valid && (alu_res == '0);
                            cout      <= alu_cout;
                            overflow  <= alu_ovf;
                        end
                    end
                end
                ST_MUL: begin
                    prod_hi  <= next_hi;
                    prod_lo  <= next_lo;
                    iter_cnt <= iter_cnt + CW'(1);
                    if (iter_cnt == LAST_ITER) begin
                        state     <= ST_DONE;
                        done      <= 1'b1;
                        iter_cnt  <= '0;
                        result    <= next_lo;
                        result_hi <= next_hi;
                        zero      <= ({next_hi, next_lo} == '0);
                        cout      <= 1'b0;
                        overflow  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - self-checking bench for alu_multicycle at WIDTH=32 and WIDTH=8
module tb_alu_multicycle;
    import alu_pkg::*;

    typedef struct packed {
        logic [63:0] res;
        logic [63:0] hi;
        logic        z;
        logic        c;
        logic        v;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        start32, start8;
    logic [3:0]  op32, op8;
    logic [31:0] a32, b32, res32, hi32;
    logic [7:0]  a8, b8, res8, hi8;
    logic        z32, c32, v32, busy32, done32;
    logic        z8, c8, v8, busy8, done8;

    logic        use8;
    logic [63:0] obs_res, obs_hi;
    logic        obs_z, obs_c, obs_v, obs_busy, obs_done;

    int checks = 0;
    int errors = 0;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start32), .op(op32), .a(a32), .b(b32),
        .result(res32), .result_hi(hi32), .zero(z32), .cout(c32), .overflow(v32),
        .busy(busy32), .done(done32)
    );

    alu_multicycle #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .result(res8), .result_hi(hi8), .zero(z8), .cout(c8), .overflow(v8),
        .busy(busy8), .done(done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (use8) begin
            obs_res  = {56'd0, res8};
            obs_hi   = {56'd0, hi8};
            obs_z    = z8;
            obs_c    = c8;
            obs_v    = v8;
            obs_busy = busy8;
            obs_done = done8;
        end else begin
            obs_res  = {32'd0, res32};
            obs_hi   = {32'd0, hi32};
            obs_z    = z32;
            obs_c    = c32;
            obs_v    = v32;
            obs_busy = busy32;
            obs_done = done32;
        end
    end

    // Reference: plain integer arithmetic on w-bit values
    function automatic exp_t model(input int w, input logic [3:0] op,
                                   input logic [63:0] a, input logic [63:0] b);
        exp_t         e;
        logic [127:0] mask, aa, bb, full;
        longint       sa, sb;
        logic         na, nb, nr;
        e    = '0;
        mask = (128'd1 << w) - 128'd1;
        aa   = {64'd0, a} & mask;
        bb   = {64'd0, b} & mask;
        na   = aa[w-1];
        nb   = bb[w-1];
        sa   = na ? longint'(aa[63:0]) - (longint'(1) << w) : longint'(aa[63:0]);
        sb   = nb ? longint'(bb[63:0]) - (longint'(1) << w) : longint'(bb[63:0]);
        case (op)
            OP_AND: e.res = aa[63:0] & bb[63:0];
            OP_OR:  e.res = aa[63:0] | bb[63:0];
            OP_NOR: begin
                full  = ~(aa | bb) & mask;
                e.res = full[63:0];
            end
            OP_ADD: begin
                full  = aa + bb;
                e.c   = (full > mask);
                full  = full & mask;
                e.res = full[63:0];
                nr    = e.res[w-1];
                e.v   = (na == nb) && (nr != na);
            end
            OP_SUB: begin
                full  = (aa - bb) & mask;
                e.res = full[63:0];
                e.c   = (aa >= bb);
                nr    = e.res[w-1];
                e.v   = (na != nb) && (nr != na);
            end
            OP_SLT: begin
                e.res = (sa < sb) ? 64'd1 : 64'd0;
                e.c   = (aa >= bb);
            end
            OP_MUL: begin
                full  = aa * bb;
                e.res = 64'(full & mask);
                e.hi  = 64'((full >> w) & mask);
            end
            default: return e;
        endcase
        e.z = (e.res == 64'd0) && (e.hi == 64'd0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic s, input logic [3:0] o,
                         input logic [63:0] x, input logic [63:0] y);
        if (w == 8) begin
            start8 = s; op8 = o; a8 = x[7:0]; b8 = y[7:0];
        end else begin
            start32 = s; op32 = o; a32 = x[31:0]; b32 = y[31:0];
        end
    endtask

    task automatic set_start(input int w, input logic s);
        if (w == 8) start8 = s;
        else        start32 = s;
    endtask

    // Issue one request, poke start while busy at cycle 'poke', then try a start in the DONE cycle
    task automatic run_op(input int w, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input int poke);
        exp_t  e;
        int    k;
        int    busy_bad;
        string t;
        e    = model(w, op, a, b);
        t    = $sformatf("w%0d_op%b_a%h_b%h", w, op, a, b);
        use8 = (w == 8);
        @(negedge clk);
        drive(w, 1'b1, op, a, b);
        @(posedge clk);
        #1;
        drive(w, 1'b0, OP_ADD, {$urandom, $urandom}, {$urandom, $urandom});
        k        = 0;
        busy_bad = 0;
        while (obs_done !== 1'b1 && k < w + 5) begin
            if (obs_busy !== 1'b1) busy_bad++;
            set_start(w, k == poke);
            @(posedge clk);
            #1;
            k++;
        end
        set_start(w, 1'b0);
        check({t, "_latency"}, 64'(k + 1), (op == OP_MUL) ? 64'(w + 1) : 64'd1);
        check({t, "_busy_wait"}, 64'(busy_bad), 64'd0);
        check({t, "_busy"}, {63'd0, obs_busy}, 64'd1);
        check({t, "_result"}, obs_res, e.res);
        check({t, "_result_hi"}, obs_hi, e.hi);
        check({t, "_zero"}, {63'd0, obs_z}, {63'd0, e.z});
        check({t, "_cout"}, {63'd0, obs_c}, {63'd0, e.c});
        check({t, "_overflow"}, {63'd0, obs_v}, {63'd0, e.v});
        drive(w, 1'b1, OP_ADD, 64'd1, 64'd1);
        @(posedge clk);
        #1;
        drive(w, 1'b0, OP_ADD, 64'd0, 64'd0);
        check({t, "_done_pulse"}, {63'd0, obs_done}, 64'd0);
        check({t, "_idle_busy"}, {63'd0, obs_busy}, 64'd0);
        check({t, "_held"}, obs_res, e.res);
    endtask

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return 64'hFFFF_FFFF;
            3:       return 64'h8000_0000;
            4:       return 64'h7FFF_FFFF;
            default: return {32'd0, $urandom};
        endcase
    endfunction

    initial begin
        logic [3:0] ops [9];
        logic [3:0] rop;
        int         n_done;
        ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MUL, 4'b0011, 4'b1111};
        use8  = 1'b0;
        rst_n = 1'b0;
        drive(32, 1'b0, OP_AND, 64'd0, 64'd0);
        drive(8, 1'b0, OP_AND, 64'd0, 64'd0);
        #12;
        check("rst_result", obs_res, 64'd0);
        check("rst_result_hi", obs_hi, 64'd0);
        check("rst_flags", {61'd0, obs_z, obs_c, obs_v}, 64'd0);
        check("rst_busy_done", {62'd0, obs_busy, obs_done}, 64'd0);

        @(posedge clk);
        #2 rst_n = 1'b1;
        run_op(32, OP_ADD, 64'h7FFF_FFFF, 64'd1, -1);
        check("add_ovf_vector", {obs_res, 61'd0, obs_z, obs_c, obs_v},
              {64'h8000_0000, 64'd1});
        run_op(32, OP_SUB, 64'd5, 64'd5, -1);
        check("sub_eq_vector", {63'd0, obs_z}, 64'd1);
        run_op(32, OP_SLT, 64'hFFFF_FFFF, 64'd1, -1);
        check("slt_vector", obs_res, 64'd1);
        run_op(32, OP_NOR, 64'hF0F0_F0F0, 64'h0F0F_0F00, -1);
        check("nor_vector", obs_res, 64'h0000_000F);
        run_op(32, OP_AND, 64'hF0F0_F0F0, 64'h0F0F_0F00, -1);
        run_op(32, OP_OR, 64'hF0F0_F0F0, 64'h0F0F_0F00, -1);
        check("or_vector", obs_res, 64'hFFFF_FFF0);
        run_op(32, 4'b0011, 64'h1234, 64'h5678, -1);
        run_op(32, OP_MUL, 64'hFFFF_FFFF, 64'd2, 10);
        check("mul_vector", {obs_hi, obs_res}, {64'd1, 64'hFFFF_FFFE});

        for (int i = 0; i < 40; i++) begin
            rop = ops[$urandom_range(0, 8)];
            run_op(32, rop, rand_operand(), rand_operand(),
                   (rop == OP_MUL && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, 30)) : -1);
        end

        run_op(32, OP_ADD, 64'h7FFF_FFFF, 64'd1, -1);
        use8 = 1'b0;
        @(negedge clk);
        drive(32, 1'b1, OP_MUL, 64'd7, 64'd9);
        @(posedge clk);
        #1 drive(32, 1'b0, OP_MUL, 64'd0, 64'd0);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_result", obs_res, 64'd0);
        check("abort_result_hi", obs_hi, 64'd0);
        check("abort_flags", {61'd0, obs_z, obs_c, obs_v}, 64'd0);
        check("abort_busy_done", {62'd0, obs_busy, obs_done}, 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done32 === 1'b1) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'd0);
        run_op(32, OP_ADD, 64'd3, 64'd4, -1);
        check("add_after_abort", obs_res, 64'd7);

        run_op(8, OP_MUL, 64'hFF, 64'hFF, 3);
        check("mul8_vector", {obs_hi, obs_res}, {64'hFE, 64'h01});
        for (int i = 0; i < 12; i++) begin
            rop = ops[$urandom_range(0, 8)];
            run_op(8, rop, {32'd0, $urandom}, {32'd0, $urandom}, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
